// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default link settings.
// Used by the RX path and by the TX block that will share this link.
package uart_pkg;

  // 100 MHz system clock at 9600 baud.
  localparam int unsigned CLKS_PER_BIT_DEF = 10416;
  localparam int unsigned DATA_BITS_DEF    = 8;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous board inputs; resets to all ones so an
// idle-high line does not look active while reset is released.
module uart_rx_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver: mid-bit sampling via a baud counter, LSB-first deserialize,
// valid/ready output with frame-error and overrun pulses.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset_p,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 w_rx_s;

  logic [2:0]           r_state;
  logic [BAUD_W-1:0]    r_baud_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic [2:0]           w_state_next;
  logic [BAUD_W-1:0]    w_baud_next;
  logic [BIT_W-1:0]     w_bit_next;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [DATA_BITS-1:0] w_data_next;
  logic                 w_valid_next;
  logic                 w_byte_done;
  logic                 w_stop_err;
  logic                 w_overrun_next;

  uart_rx_sync #(
    .WIDTH (1)
  ) u_rx_sync (
    .clk     (clk),
    .reset_p (reset_p),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  // Frame FSM and baud/bit counters.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud_cnt;
    w_bit_next   = r_bit_cnt;
    w_shift_next = r_shift;
    w_byte_done  = 1'b0;
    w_stop_err   = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_next = START;
          w_baud_next  = '0;
        end
      end

      START: begin
        if (r_baud_cnt == BAUD_HALF) begin
          if (!w_rx_s) begin
            w_state_next = DATA;
            w_baud_next  = '0;
            w_bit_next   = '0;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_baud_next = r_baud_cnt + 1'b1;
        end
      end

      DATA: begin
        if (r_baud_cnt == BAUD_FULL) begin
          w_shift_next = {w_rx_s, r_shift[DATA_BITS-1:1]};
          w_bit_next   = r_bit_cnt + 1'b1;
          w_baud_next  = '0;
          if (r_bit_cnt == BIT_LAST) begin
            w_state_next = STOP;
          end
        end else begin
          w_baud_next = r_baud_cnt + 1'b1;
        end
      end

      STOP: begin
        // Returning to IDLE mid-stop-bit lets a back-to-back start bit be caught.
        if (r_baud_cnt == BAUD_FULL) begin
          w_baud_next = '0;
          if (w_rx_s) begin
            w_byte_done  = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_stop_err   = 1'b1;
            w_state_next = WAIT_HIGH;
          end
        end else begin
          w_baud_next = r_baud_cnt + 1'b1;
        end
      end

      WAIT_HIGH: begin
        if (w_rx_s) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Output port: a completed byte is dropped if the previous one is still held.
  always_comb begin
    w_data_next    = r_data;
    w_valid_next   = r_valid;
    w_overrun_next = 1'b0;

    if (w_byte_done) begin
      if (!r_valid || i_ready) begin
        w_data_next  = r_shift;
        w_valid_next = 1'b1;
      end else begin
        w_overrun_next = 1'b1;
      end
    end else if (r_valid && i_ready) begin
      w_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state     <= IDLE;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_baud_cnt  <= w_baud_next;
      r_bit_cnt   <= w_bit_next;
      r_shift     <= w_shift_next;
      r_data      <= w_data_next;
      r_valid     <= w_valid_next;
      r_frame_err <= w_stop_err;
      r_overrun   <= w_overrun_next;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);

endmodule
